// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit for the execute stage
module ex_muldiv #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] src1_i,
   input  logic [XLEN-1:0] src2_i,
   input  logic [4:0]      rd_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [4:0]        rd_q, rd_d;
   logic              neg1_q, neg1_d, neg2_q, neg2_d;
   logic [XLEN-1:0]   opa_q, opa_d;       // multiplicand (mul) or divisor (div) magnitude
   logic [2*XLEN-1:0] acc_q, acc_d;       // product accumulator, multiplier in low half
   logic [XLEN-1:0]   quo_q, quo_d;       // dividend shifting out, quotient shifting in
   logic [XLEN-1:0]   rem_q, rem_d;       // partial remainder, always below the divisor
   logic [XLEN-1:0]   res_q, res_d;
   logic [4:0]        rdo_q, rdo_d;

   // operand decode at start
   logic              sgn1, sgn2, neg1, neg2, div_zero, div_ovf;
   logic [XLEN-1:0]   mag1, mag2, spec_res;

   // one radix-2 step plus the sign-fixed results of the final step
   logic [XLEN:0]     msum;
   logic [2*XLEN-1:0] acc_step, prod_f;
   logic [XLEN:0]     rsh;
   logic [XLEN+1:0]   diff;
   logic              ge;
   logic [XLEN-1:0]   rem_step, quo_step, quo_f, rem_f;

   assign done_o   = (state_q == DONE);
   assign result_o = res_q;
   assign rd_o     = rdo_q;

   // operand signedness, magnitudes and the cases that skip iteration
   always_comb begin
      sgn1     = (op_i != 3'd3) && (op_i != 3'd5) && (op_i != 3'd7);
      sgn2     = (op_i == 3'd0) || (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
      neg1     = sgn1 && src1_i[XLEN-1];
      neg2     = sgn2 && src2_i[XLEN-1];
      mag1     = neg1 ? (~src1_i + 1'b1) : src1_i;
      mag2     = neg2 ? (~src2_i + 1'b1) : src2_i;
      div_zero = op_i[2] && (src2_i == '0);
      div_ovf  = op_i[2] && !op_i[0] && (src1_i == {1'b1, {(XLEN-1){1'b0}}}) && (src2_i == '1);
      if (div_zero) spec_res = op_i[1] ? src1_i : '1;
      else          spec_res = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   // shift-add and restoring shift-subtract datapath
   always_comb begin
      msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opa_q : {XLEN{1'b0}})};
      acc_step = {msum, acc_q[XLEN-1:1]};
      rsh      = {rem_q, quo_q[XLEN-1]};
      diff     = {1'b0, rsh} - {2'b00, opa_q};
      ge       = !diff[XLEN+1];
      rem_step = ge ? diff[XLEN-1:0] : rsh[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], ge};
      prod_f   = (neg1_q ^ neg2_q) ? (~acc_step + 1'b1) : acc_step;
      quo_f    = (neg1_q ^ neg2_q) ? (~quo_step + 1'b1) : quo_step;
      rem_f    = neg1_q ? (~rem_step + 1'b1) : rem_step;
   end

   // next-state, datapath update and stall request
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rd_d    = rd_q;
      neg1_d  = neg1_q;
      neg2_d  = neg2_q;
      opa_d   = opa_q;
      acc_d   = acc_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      res_d   = res_q;
      rdo_d   = rdo_q;
      stall_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i && !flush_i) begin
               stall_o = 1'b1;
               op_d    = op_i;
               rd_d    = rd_i;
               neg1_d  = neg1;
               neg2_d  = neg2;
               opa_d   = op_i[2] ? mag2 : mag1;
               acc_d   = {{XLEN{1'b0}}, mag2};
               quo_d   = mag1;
               rem_d   = '0;
               cnt_d   = '0;
               if (div_zero || div_ovf) begin
                  res_d   = spec_res;
                  rdo_d   = rd_i;
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            stall_o = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            acc_d   = acc_step;
            quo_d   = quo_step;
            rem_d   = rem_step;
            if (cnt_q == {CNT_W{1'b1}}) begin
               case (op_q)
                  3'd0:          res_d = prod_f[XLEN-1:0];
                  3'd1, 3'd2,
                  3'd3:          res_d = prod_f[2*XLEN-1:XLEN];
                  3'd4, 3'd5:    res_d = quo_f;
                  default:       res_d = rem_f;
               endcase
               rdo_d   = rd_q;
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // a flushed op leaves the visible result untouched
      if (flush_i) begin
         state_d = IDLE;
         res_d   = res_q;
         rdo_d   = rdo_q;
      end
   end

   // state and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         rd_q    <= '0;
         neg1_q  <= 1'b0;
         neg2_q  <= 1'b0;
         opa_q   <= '0;
         acc_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         res_q   <= '0;
         rdo_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         neg1_q  <= neg1_d;
         neg2_q  <= neg2_d;
         opa_q   <= opa_d;
         acc_q   <= acc_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         res_q   <= res_d;
         rdo_q   <= rdo_d;
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush_i;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] src1_i;
   logic [31:0] src2_i;
   logic [4:0]  rd_i;
   logic        stall_o;
   logic        done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int last_done   = 0;
   int first_done  = 0;
   int done_seen;

   ex_muldiv #(.XLEN(32), .CNT_W(5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush_i  (flush_i),
      .start_i  (start_i),
      .op_i     (op_i),
      .src1_i   (src1_i),
      .src2_i   (src2_i),
      .rd_i     (rd_i),
      .stall_o  (stall_o),
      .done_o   (done_o),
      .result_o (result_o),
      .rd_o     (rd_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called just after a posedge with the unit in IDLE; returns on the done cycle's negedge.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input bit hold,
                         input int exp_edges, input logic [31:0] exp_res);
      int edges;
      int stalls;
      bit got;
      edges  = 0;
      stalls = 0;
      got    = 1'b0;
      start_i = 1'b1;
      op_i    = op;
      src1_i  = a;
      src2_i  = b;
      rd_i    = rd;
      while (!got && edges < 100) begin
         @(negedge clk);
         if (done_o) begin
            got = 1'b1;
         end else begin
            if (stall_o) stalls++;
            @(posedge clk);
            #1;
            edges++;
         end
      end
      last_done = cyc;
      chk({tag, " done"}, {31'd0, got}, 32'd1);
      chk({tag, " latency"}, edges, exp_edges);
      chk({tag, " stall cycles"}, stalls, exp_edges);
      chk({tag, " stall in done"}, {31'd0, stall_o}, 32'd0);
      chk({tag, " result"}, result_o, exp_res);
      chk({tag, " rd"}, {27'd0, rd_o}, {27'd0, rd});
      if (!hold) start_i = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      flush_i = 1'b0;
      start_i = 1'b0;
      op_i    = 3'd0;
      src1_i  = 32'd0;
      src2_i  = 32'd0;
      rd_i    = 5'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset done", {31'd0, done_o}, 32'd0);
      chk("reset result", result_o, 32'd0);
      chk("reset rd", {27'd0, rd_o}, 32'd0);
      chk("reset stall", {31'd0, stall_o}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // basic multiply, then confirm single-cycle done and held result
      run_op("mul 7x6", 3'd0, 32'd7, 32'd6, 5'd5, 1'b0, 33, 32'h0000_002A);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mul hold done", {31'd0, done_o}, 32'd0);
      chk("mul hold result", result_o, 32'h0000_002A);
      chk("mul hold rd", {27'd0, rd_o}, 32'd5);
      chk("mul hold stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;

      run_op("mul -3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, 5'd1, 1'b0, 33, 32'hFFFF_FFF1);
      @(posedge clk); #1;
      run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0, 33, 32'h0000_0000);
      @(posedge clk); #1;
      run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, 33, 32'hFFFF_FFFE);
      @(posedge clk); #1;
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 1'b0, 33, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      run_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0, 33, 32'hFFFF_FFFD);
      @(posedge clk); #1;
      run_op("rem -7%2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0, 33, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      run_op("divu 100/7", 3'd5, 32'd100, 32'd7, 5'd8, 1'b0, 33, 32'd14);
      @(posedge clk); #1;
      run_op("remu 100%7", 3'd7, 32'd100, 32'd7, 5'd9, 1'b0, 33, 32'd2);
      @(posedge clk); #1;

      // special cases finish one cycle after start
      run_op("div by 0", 3'd4, 32'h0000_1234, 32'd0, 5'd10, 1'b0, 1, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      run_op("rem by 0", 3'd6, 32'h0000_1234, 32'd0, 5'd11, 1'b0, 1, 32'h0000_1234);
      @(posedge clk); #1;
      run_op("divu by 0", 3'd5, 32'h0000_1234, 32'd0, 5'd12, 1'b0, 1, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      run_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0, 1, 32'h8000_0000);
      @(posedge clk); #1;
      run_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0, 1, 32'h0000_0000);
      @(posedge clk); #1;

      // flush together with start in IDLE starts nothing
      start_i = 1'b1; flush_i = 1'b1; op_i = 3'd5; src1_i = 32'd50; src2_i = 32'd5; rd_i = 5'd20;
      @(negedge clk);
      chk("flush+start stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
      start_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      chk("flush+start done", {31'd0, done_o}, 32'd0);
      chk("flush+start stall after", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;

      // flush at RUN cycle 10: no done, result untouched
      start_i = 1'b1; op_i = 3'd5; src1_i = 32'd100; src2_i = 32'd7; rd_i = 5'd21;
      @(posedge clk); #1;
      start_i = 1'b0;
      src1_i = 32'd9; src2_i = 32'd1; op_i = 3'd0;
      repeat (9) @(posedge clk);
      #1;
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      @(negedge clk);
      chk("flush stall", {31'd0, stall_o}, 32'd0);
      chk("flush done", {31'd0, done_o}, 32'd0);
      chk("flush result", result_o, 32'h0000_0000);
      chk("flush rd", {27'd0, rd_o}, 32'd14);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done_o) done_seen++;
      end
      chk("flush no done", done_seen, 0);
      @(posedge clk); #1;

      // reset at RUN cycle 10 clears the visible result
      run_op("divu pre", 3'd5, 32'd100, 32'd7, 5'd22, 1'b0, 33, 32'd14);
      @(posedge clk); #1;
      start_i = 1'b1; op_i = 3'd5; src1_i = 32'd100; src2_i = 32'd7; rd_i = 5'd23;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst mid stall", {31'd0, stall_o}, 32'd0);
      chk("rst mid done", {31'd0, done_o}, 32'd0);
      chk("rst mid result", result_o, 32'd0);
      chk("rst mid rd", {27'd0, rd_o}, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done_o) done_seen++;
      end
      chk("rst mid no done", done_seen, 0);
      @(posedge clk); #1;

      // back-to-back: start held through DONE, next op issued right after
      run_op("b2b mul 3x4", 3'd0, 32'd3, 32'd4, 5'd15, 1'b1, 33, 32'd12);
      first_done = last_done;
      @(posedge clk); #1;
      run_op("b2b divu 9/3", 3'd5, 32'd9, 32'd3, 5'd16, 1'b0, 33, 32'd3);
      chk("b2b spacing", last_done - first_done, 34);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b idle done", {31'd0, done_o}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
